coefficient_loader: RTL

COEFFICIENT_LOADER -- requirements
Module: coefficient_loader

---
 rtl/coeff_loader_pkg.sv | 16 +
 rtl/coeff_timeout_timer.sv | 30 +++
 rtl/coefficient_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/coeff_loader_pkg.sv
// Shared types and constants for the FIR coefficient loader.
package coeff_loader_pkg;

  localparam int NUM_COEFFS             = 4;
  localparam int COEFF_IDX_W            = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ACK,
    WAIT,
    DONE
  } coeff_state_e;

endpackage

// File: rtl/coeff_timeout_timer.sv
// Stall timer for the coefficient loader: counts cycles spent waiting on the FIR
// and flags the last permitted cycle.
module coeff_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic count_enable,
  output logic rollover
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Flags the TIMEOUT_CYCLES-th waiting cycle so the FSM leaves on that edge.
  assign rollover = count_enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/coefficient_loader.sv
// Sequences a pending coefficient set from the AHB slave into the FIR, one slot at a time.
// Optional stall timeout with load_err reporting is enabled by defining COEFF_LOAD_TIMEOUT_EN.
module coefficient_loader
  import coeff_loader_pkg::*;
#(
  parameter int NUM_COEFFS     = coeff_loader_pkg::NUM_COEFFS,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   new_coefficient_set,
  input  logic                   modwait,
  output logic                   load_coeff,
  output logic [COEFF_IDX_W-1:0] coefficient_num,
  output logic                   clear_new_coeff_set,
  output logic                   load_busy,
  output logic                   load_err
);

  localparam logic [COEFF_IDX_W-1:0] LAST_IDX = COEFF_IDX_W'(NUM_COEFFS - 1);

  coeff_state_e           state_q, state_d;
  logic [COEFF_IDX_W-1:0] idx_q, idx_d;
  logic                   timeout;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (new_coefficient_set && !modwait) begin
          state_d = ISSUE;
          idx_d   = '0;
        end
      end
      ISSUE: state_d = ACK;
      ACK: begin
        if (timeout)      state_d = DONE;
        else if (modwait) state_d = WAIT;
      end
      WAIT: begin
        // The last slot exits before incrementing, so the index never wraps.
        if (timeout) begin
          state_d = DONE;
        end else if (!modwait) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            idx_d   = idx_q + COEFF_IDX_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load_coeff          = (state_q == ISSUE);
  assign clear_new_coeff_set = (state_q == DONE);
  assign load_busy           = (state_q != IDLE);
  assign coefficient_num     = idx_q;

`ifdef COEFF_LOAD_TIMEOUT_EN
  logic waiting;
  logic timer_clear;
  logic load_err_q;

  assign waiting     = (state_q == ACK) || (state_q == WAIT);
  // Any state change restarts the count, so each ACK/WAIT entry begins at zero.
  assign timer_clear = (state_d != state_q);

  coeff_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (timer_clear),
    .count_enable (waiting),
    .rollover     (timeout)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      load_err_q <= 1'b0;
    end else if ((state_q == IDLE) && (state_d == ISSUE)) begin
      load_err_q <= 1'b0;
    end else if (timeout) begin
      load_err_q <= 1'b1;
    end
  end

  assign load_err = load_err_q;
`else
  assign timeout  = 1'b0;
  assign load_err = 1'b0;
`endif

endmodule
